snake_head_stepper: RTL

Generates the snake head's grid position once per movement tick from player direction pulses. Sits directly upstream of the 8-bit head-position register and drives its D input with the packed coordinate {y[3:0], x[3:0]}. Each move is flagged with a one-cycle `step` strobe, which the register's clock-enable/load logic and the body-segment shifter use.

---
 rtl/snake_head_stepper.sv | 106 ++++++++++
 1 files changed

// File: rtl/snake_head_stepper.sv
// Snake head position generator: captures direction presses and advances the
// packed {y,x} head coordinate once per movement tick, flagging each move with step.
module snake_head_stepper #(
   parameter int         TICK_DIV  = 4,
   parameter logic [7:0] START_POS = 8'h88
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       set,
   input  logic       pause,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [7:0] head_pos,
   output logic [1:0] dir,
   output logic       step
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_UP    = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_DOWN  = 2'b11
   } dir_e;

   logic [7:0]    head_q, head_d;
   dir_e          dir_q, dir_d;
   dir_e          pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          step_q, step_d;

   logic          any_btn;
   logic          cand_ok;
   logic          terminal;
   dir_e          cand;
   dir_e          pend_eff;

   always_comb begin
      any_btn = btn_up | btn_down | btn_left | btn_right;
      if (btn_up)
         cand = DIR_UP;
      else if (btn_down)
         cand = DIR_DOWN;
      else if (btn_left)
         cand = DIR_LEFT;
      else
         cand = DIR_RIGHT;
      // Opposite directions differ only in the upper encoding bit.
      cand_ok  = any_btn && (cand != dir_e'(dir_q ^ 2'b10));
      pend_eff = cand_ok ? cand : pend_q;
      terminal = !pause && (cnt_q == LAST);

      head_d = head_q;
      dir_d  = dir_q;
      pend_d = pend_eff;
      cnt_d  = cnt_q;
      step_d = 1'b0;

      if (!pause)
         cnt_d = terminal ? '0 : cnt_q + 1'b1;

      if (terminal) begin
         dir_d  = pend_eff;
         step_d = 1'b1;
         case (pend_eff)
            DIR_RIGHT: head_d = {head_q[7:4], head_q[3:0] + 4'd1};
            DIR_UP:    head_d = {head_q[7:4] - 4'd1, head_q[3:0]};
            DIR_LEFT:  head_d = {head_q[7:4], head_q[3:0] - 4'd1};
            default:   head_d = {head_q[7:4] + 4'd1, head_q[3:0]};
         endcase
      end

      if (set) begin
         head_d = START_POS;
         dir_d  = DIR_RIGHT;
         pend_d = DIR_RIGHT;
         cnt_d  = '0;
         step_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         head_q <= START_POS;
         dir_q  <= DIR_RIGHT;
         pend_q <= DIR_RIGHT;
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else begin
         head_q <= head_d;
         dir_q  <= dir_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         step_q <= step_d;
      end
   end

   assign head_pos = head_q;
   assign dir      = dir_q;
   assign step     = step_q;

endmodule
